// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, 12-bit colour type and the 16-entry palette
package vga_pkg;
   localparam int CLK_DIV = 4;
   localparam int FB_W = 320;
   localparam int FB_H = 240;
   localparam int H_VIS = 640;
   localparam int H_FP = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP = 48;
   localparam int V_VIS = 480;
   localparam int V_FP = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP = 33;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;
   // 5 (sky) and B (ground) match the framebuffer clear pattern
   localparam rgb12_t PALETTE [16] = '{
      12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'h5AF, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h3A3, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel strobe divider, h/v raster counters and sync/visible decode
module vga_timing #(
   parameter int CLK_DIV = vga_pkg::CLK_DIV,
   parameter int H_VIS = vga_pkg::H_VIS,
   parameter int H_FP = vga_pkg::H_FP,
   parameter int H_SYNC = vga_pkg::H_SYNC,
   parameter int H_BP = vga_pkg::H_BP,
   parameter int V_VIS = vga_pkg::V_VIS,
   parameter int V_FP = vga_pkg::V_FP,
   parameter int V_SYNC = vga_pkg::V_SYNC,
   parameter int V_BP = vga_pkg::V_BP
) (
   input  logic       clock,
   input  logic       reset,
   output logic       pix_stb,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       vis,
   output logic       hs,
   output logic       vs
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW = $clog2(CLK_DIV);
   logic [DW-1:0] div_cnt;
   assign pix_stb = div_cnt == DW'(CLK_DIV - 1);
   assign vis = h < 10'(H_VIS) && v < 10'(V_VIS);
   assign hs = !(h >= 10'(H_VIS + H_FP) && h < 10'(H_VIS + H_FP + H_SYNC));
   assign vs = !(v >= 10'(V_VIS + V_FP) && v < 10'(V_VIS + V_FP + V_SYNC));
   always_ff @(posedge clock)
      if (reset) begin
         div_cnt <= '0;
         h <= '0;
         v <= '0;
      end else begin
         div_cnt <= pix_stb ? '0 : div_cnt + 1'b1;
         if (pix_stb) begin
            h <= h == 10'(H_TOT - 1) ? '0 : h + 10'd1;
            if (h == 10'(H_TOT - 1))
               v <= v == 10'(V_TOT - 1) ? '0 : v + 10'd1;
         end
      end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: 2x-scaled framebuffer scanout with palette lookup and a 2-strobe pipeline to the pins
module vga_scanout #(
   parameter int CLK_DIV = vga_pkg::CLK_DIV,
   parameter int FB_W = vga_pkg::FB_W,
   parameter int FB_H = vga_pkg::FB_H,
   parameter int H_VIS = vga_pkg::H_VIS,
   parameter int H_FP = vga_pkg::H_FP,
   parameter int H_SYNC = vga_pkg::H_SYNC,
   parameter int H_BP = vga_pkg::H_BP,
   parameter int V_VIS = vga_pkg::V_VIS,
   parameter int V_FP = vga_pkg::V_FP,
   parameter int V_SYNC = vga_pkg::V_SYNC,
   parameter int V_BP = vga_pkg::V_BP
) (
   input  logic        clock,
   input  logic        reset,
   output logic [18:0] addr_vga,
   input  logic [3:0]  data_vga,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);
   import vga_pkg::*;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   logic        pix_stb, vis, hs, vs;
   logic        vis_d, hs_d, vs_d, fs_d;
   logic [9:0]  h, v;
   logic [18:0] line_base;
   vga_timing #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) timing (
      .clock(clock), .reset(reset), .pix_stb(pix_stb), .h(h), .v(v),
      .vis(vis), .hs(hs), .vs(vs)
   );
   // line_base steps by FB_W after every odd line, so each framebuffer row is shown twice
   always_ff @(posedge clock)
      if (reset) begin
         line_base <= '0;
         addr_vga <= '0;
         {vis_d, hs_d, vs_d, fs_d} <= 4'b0110;
         {vga_r, vga_g, vga_b} <= '0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_stb && fs_d;
         if (pix_stb) begin
            if (h == 10'(H_TOT - 1))
               line_base <= v == 10'(V_TOT - 1) ? '0 :
                            line_base + (v < 10'(2 * FB_H - 1) && v[0] ? 19'(FB_W) : 19'd0);
            addr_vga <= vis ? line_base + 19'(h[9:1]) : '0;
            vis_d <= vis;
            hs_d <= hs;
            vs_d <= vs;
            fs_d <= h == '0 && v == '0;
            {vga_r, vga_g, vga_b} <= vis_d ? PALETTE[data_vga] : '0;
            vga_hsync <= hs_d;
            vga_vsync <= vs_d;
         end
      end
endmodule
